// File: rtl/bi_dir_serializer_pkg.sv
// Shared types and constants for the bi-directional serial link
// (transmit serializer and its matching receive shift register).
package bi_dir_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/bi_dir_serializer_frame_bit_counter.sv
// Frame bit counter: counts bit positions 0..WIDTH-1 within a frame and flags
// the last position. Shared with the receive side of the link.
module frame_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bi_dir_serializer.sv
// Parallel-in, serial-out transmitter with selectable bit order, frame-start and
// last-bit markers, gap-free back-to-back frames and shift_en stalling.
//
//   state | meaning
//   IDLE  | no frame in progress, ready for a word
//   SHIFT | frame being transmitted, one bit per enabled cycle
module bi_dir_serializer
  import bi_dir_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             r_dir_q;
  logic             w_dir_nxt;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             r_svalid;
  logic             w_svalid_nxt;
  logic             r_fstart;
  logic             w_fstart_nxt;
  logic             r_flast;
  logic             w_flast_nxt;

  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_nxt_idx;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_load_ready;
  logic             w_accept;

  frame_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .o_cnt    (w_cnt),
    .o_tc     (w_tc)
  );

  // Position of the bit that goes on the wire after the current one.
  assign w_cnt_inc = w_cnt + CNT_W'(1);
  assign w_nxt_idx = (r_dir_q == DIR_MSB_FIRST) ? (CNT_W'(WIDTH - 2) - w_cnt) : w_cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_dir_nxt    = r_dir_q;
    w_sout_nxt   = r_sout;
    w_svalid_nxt = r_svalid;
    w_fstart_nxt = r_fstart;
    w_flast_nxt  = r_flast;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;

    // Accepting during the last enabled bit chains the next frame with no gap.
    w_load_ready = rst && ((r_state == IDLE) || ((r_state == SHIFT) && w_tc && shift_en));
    w_accept     = load_valid && w_load_ready;

    if (w_accept) begin
      w_state_nxt  = SHIFT;
      w_shreg_nxt  = din;
      w_dir_nxt    = dir;
      w_sout_nxt   = (dir == DIR_MSB_FIRST) ? din[WIDTH-1] : din[0];
      w_svalid_nxt = 1'b1;
      w_fstart_nxt = 1'b1;
      w_flast_nxt  = 1'b0;
      w_cnt_clr    = 1'b1;
    end else if ((r_state == SHIFT) && shift_en) begin
      if (w_tc) begin
        w_state_nxt  = IDLE;
        w_sout_nxt   = 1'b0;
        w_svalid_nxt = 1'b0;
        w_fstart_nxt = 1'b0;
        w_flast_nxt  = 1'b0;
        w_cnt_clr    = 1'b1;
      end else begin
        w_cnt_en     = 1'b1;
        w_sout_nxt   = r_shreg[w_nxt_idx];
        w_fstart_nxt = 1'b0;
        w_flast_nxt  = (w_cnt_inc == CNT_W'(WIDTH - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg  <= '0;
      r_dir_q  <= DIR_LSB_FIRST;
      r_sout   <= 1'b0;
      r_svalid <= 1'b0;
      r_fstart <= 1'b0;
      r_flast  <= 1'b0;
    end else begin
      r_shreg  <= w_shreg_nxt;
      r_dir_q  <= w_dir_nxt;
      r_sout   <= w_sout_nxt;
      r_svalid <= w_svalid_nxt;
      r_fstart <= w_fstart_nxt;
      r_flast  <= w_flast_nxt;
    end
  end

  assign load_ready   = w_load_ready;
  assign serial_out   = r_sout;
  assign serial_valid = r_svalid;
  assign frame_start  = r_fstart;
  assign frame_last   = r_flast;
  assign busy         = (r_state == SHIFT);

endmodule

// File: tb/tb_bi_dir_serializer.sv
// Directed bench for bi_dir_serializer (WIDTH=4); expected serial bits and
// markers are queued when a word is loaded and popped as the link emits them.
module tb_bi_dir_serializer;

  localparam int W = 4;

  typedef struct packed {
    logic b;
    logic s;
    logic l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         dir = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic         shift_en = 1'b1;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         frame_last;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  bi_dir_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .dir          (dir),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_last   (frame_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d, input logic dr);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b = dr ? d[W-1-i] : d[i];
      e.s = (i == 0);
      e.l = (i == W - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sv"}, serial_valid, 1'b0);
    chk({tag, "_sout"}, serial_out, 1'b0);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_fl"}, frame_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Advance one clock; with sb set, compare the emitted bit against the queue head.
  task automatic tick(input bit sb);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_valid", serial_valid, 1'b1);
        chk("sb_bit", serial_out, e.b);
        chk("sb_start", frame_start, e.s);
        chk("sb_last", frame_last, e.l);
        chk("sb_busy", busy, 1'b1);
      end else begin
        chk_idle("sb_idle");
      end
    end
  endtask

  task automatic chk_drained(input string tag);
    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=0 pending bits", tag, sb_q.size());
    end
  endtask

  initial begin
    // Reset and idle
    #23;
    chk_idle("rst");
    chk("rst_ready", load_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk("idle_ready", load_ready, 1'b1);
    end

    // LSB-first 1011 -> 1,1,0,1
    din = 4'b1011; dir = 1'b0; load_valid = 1'b1;
    #1;
    chk("lsb_ready", load_ready, 1'b1);
    push_frame(4'b1011, 1'b0);
    tick(1'b1);
    load_valid = 1'b0;
    din = 4'b0000; dir = 1'b1;
    repeat (4) tick(1'b1);
    chk_drained("lsb_drain");

    // MSB-first 1011 -> 1,0,1,1
    din = 4'b1011; dir = 1'b1; load_valid = 1'b1;
    push_frame(4'b1011, 1'b1);
    tick(1'b1);
    load_valid = 1'b0;
    repeat (4) tick(1'b1);
    chk_drained("msb_drain");

    // Back-to-back: second word presented during the last bit of the first
    din = 4'b1011; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b1011, 1'b0);
    tick(1'b1);
    load_valid = 1'b0;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    din = 4'b0110; dir = 1'b0; load_valid = 1'b1;
    #1;
    chk("b2b_ready_last", load_ready, 1'b1);
    push_frame(4'b0110, 1'b0);
    tick(1'b1);
    load_valid = 1'b0;
    repeat (4) tick(1'b1);
    chk_drained("b2b_drain");

    // Stall after bit 2; a load pulse during the frame must be ignored
    din = 4'b1011; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b1011, 1'b0);
    tick(1'b1);
    load_valid = 1'b0;
    #1;
    chk("mid_ready", load_ready, 1'b0);
    tick(1'b1);
    shift_en = 1'b0;
    din = 4'b0000; load_valid = 1'b1;
    #1;
    chk("stall_ready", load_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      chk("stall_bit", serial_out, 1'b1);
      chk("stall_valid", serial_valid, 1'b1);
      chk("stall_fs", frame_start, 1'b0);
      chk("stall_fl", frame_last, 1'b0);
      chk("stall_ready_h", load_ready, 1'b0);
    end
    load_valid = 1'b0;
    shift_en = 1'b1;
    repeat (3) tick(1'b1);
    chk_drained("stall_drain");

    // Asynchronous reset during bit 3
    din = 4'b1011; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b1011, 1'b0);
    tick(1'b1);
    load_valid = 1'b0;
    tick(1'b1);
    tick(1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_ready", load_ready, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    din = 4'b0001; dir = 1'b1; load_valid = 1'b1;
    push_frame(4'b0001, 1'b1);
    tick(1'b1);
    load_valid = 1'b0;
    repeat (4) tick(1'b1);
    chk_drained("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
